risc_v_mike_fetch_ctrl: RTL
===========================

RISC_V_MIKE_FETCH_CTRL -- requirements
Module: risc_v_mike_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0040_0000, which is the first fetch address after reset (text segment base).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, which is the number of prefetch buffer entries (legal values 2..8).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port fetch_en, input, 1 bit; when high, the block fetches.
REQ-006 The block SHALL have port imem_req, output, 1 bit, the fetch request to the instruction memory port.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit, the grant from the memory owner; imem_rd_data is valid in the same cycle.
REQ-008 The block SHALL have port imem_addr, output, 32 bits (t_pc_addr), the byte address of the fetch.
REQ-009 The block SHALL have port imem_rd_data, input, 32 bits, the instruction word returned combinationally.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit, a branch/jump redirect strobe.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits, the redirect target.
REQ-012 The block SHALL have port instr_valid, output, 1 bit, meaning the buffer head is valid.
REQ-013 The block SHALL have port instr_ready, input, 1 bit, meaning the decode stage accepts the head.
REQ-014 The block SHALL have port instr_data, output, 32 bits, the head instruction word.
REQ-015 The block SHALL have port instr_pc, output, 32 bits, the address of the head instruction.
REQ-016 The block SHALL have port misalign_err, output, 1 bit, a sticky misaligned-redirect error flag.

Function
REQ-017 The block SHALL implement the states IDLE, RUN and ERR.
REQ-018 IDLE SHALL go to RUN when fetch_en=1.
REQ-019 RUN SHALL go to IDLE when fetch_en=0.
REQ-020 Any state SHALL go to ERR on an accepted redirect with redirect_pc[1:0]!=0; ERR exits only by reset.
REQ-021 imem_req SHALL equal (state==RUN) AND (buffer not full) AND (redirect_valid==0).
REQ-022 imem_addr SHALL equal fetch_pc in every cycle.
REQ-023 A fetch SHALL complete when imem_req AND imem_gnt: {fetch_pc, imem_rd_data} is pushed and fetch_pc advances by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-024 While imem_gnt=0 with imem_req=1, imem_req and imem_addr SHALL hold and nothing SHALL be pushed.
REQ-025 instr_valid SHALL be 1 iff the buffer count is nonzero; instr_data and instr_pc SHALL be the head entry, or 0 when the buffer is empty.
REQ-026 An entry SHALL be popped when instr_valid AND instr_ready.
REQ-027 When the buffer is full, the block SHALL NOT push even if a pop occurs in that cycle; the request re-asserts the next cycle.
REQ-028 Latency SHALL be: a grant in cycle N gives instr_valid=1 with that word in cycle N+1 (no combinational path from imem_rd_data to instr_*).
REQ-029 A pop and a push in the same cycle SHALL leave the count unchanged and preserve order.
REQ-030 Redirect SHALL have highest priority in any state except ERR: buffer count -> 0 and fetch_pc -> redirect_pc on the next edge; no push that cycle; a same-cycle pop is still accepted by the consumer.
REQ-031 A redirect in IDLE SHALL update fetch_pc, so software sets the start address before enabling.
REQ-032 In IDLE, no requests SHALL be issued; existing buffer entries SHALL remain drainable.
REQ-033 In ERR, misalign_err SHALL be 1, imem_req SHALL be 0, the buffer SHALL be flushed, and instr_valid SHALL be 0.
REQ-034 Count arithmetic SHALL be $clog2(FIFO_DEPTH+1) bits wide, with wrap-free read/write pointers modulo FIFO_DEPTH.

Reset
REQ-035 While rst=0 (asynchronously), state SHALL be IDLE and fetch_pc SHALL be RESET_PC.
REQ-036 While rst=0, the buffer count and pointers SHALL be 0.
REQ-037 While rst=0, imem_req, instr_valid, instr_data, instr_pc and misalign_err SHALL all be 0.
REQ-038 Reset asserted mid-fetch SHALL discard all buffered entries; the first request after release SHALL use RESET_PC.

Verification
REQ-039 Release reset, hold fetch_en=1, imem_gnt=1, instr_ready=1, imem_rd_data=0x00100313 -> imem_addr sequence 0x00400000, 0x00400004, ...; instr_valid first high one cycle after the first grant, with instr_pc=0x00400000.
REQ-040 Hold instr_ready=0 with grants -> exactly FIFO_DEPTH pushes, then imem_req=0; raise instr_ready -> imem_req returns the cycle after the first pop, and order is preserved.
REQ-041 Pulse redirect_valid with redirect_pc=0x00400040 while the buffer holds 2 entries -> next cycle instr_valid=0 and imem_addr=0x00400040; no stale entry ever appears.
REQ-042 Pulse redirect_valid with redirect_pc=0x00400042 -> misalign_err=1, imem_req=0 and instr_valid=0 permanently until rst=0.
REQ-043 Toggle imem_gnt randomly with fetch_en=1 -> imem_addr holds while ungranted, and every instr_pc equals the previous instr_pc+4.
REQ-044 Redirect to 0xFFFFFFFC, then grant twice -> instr_pc sequence 0xFFFFFFFC, 0x00000000; and asserting rst mid-run -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/risc_v_mike_fetch_ctrl.sv
// Instruction fetch controller: issues sequential fetches to instruction memory,
// buffers returned words in a small prefetch FIFO and handles redirects.
module risc_v_mike_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        imem_req,
  input  logic        imem_gnt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];

  logic full;
  logic push;
  logic pop;
  logic redirect;
  logic bad_redirect;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full         = (count == CW'(FIFO_DEPTH));
  assign imem_req     = (state == RUN) && !full && !redirect_valid;
  assign imem_addr    = fetch_pc;
  assign push         = imem_req && imem_gnt;
  assign instr_valid  = (count != '0);
  assign pop          = instr_valid && instr_ready;
  assign redirect     = redirect_valid && (state != ERR);
  assign bad_redirect = redirect && (redirect_pc[1:0] != 2'b00);
  assign instr_data   = instr_valid ? data_mem[rd_ptr] : '0;
  assign instr_pc     = instr_valid ? pc_mem[rd_ptr] : '0;
  assign misalign_err = (state == ERR);

  // Control state, fetch PC and buffer bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (bad_redirect) begin
        state <= ERR;
      end else begin
        case (state)
          IDLE:    if (fetch_en) state <= RUN;
          RUN:     if (!fetch_en) state <= IDLE;
          default: state <= ERR;
        endcase
      end

      if (redirect) begin
        // A redirect flushes the buffer; a misaligned target leaves fetch_pc alone
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        if (!bad_redirect) fetch_pc <= redirect_pc;
      end else begin
        if (push) begin
          wr_ptr   <= next_ptr(wr_ptr);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= next_ptr(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Buffer storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= imem_rd_data;
    end
  end

endmodule
